fpga_rst_seq: RTL
=================

# fpga_rst_seq

FPGA board-level clock/reset sequencer for the PULPissimo FPGA wrappers. It runs on the free-running board reference clock, upstream of the MMCM. It pulses the MMCM reset and waits for lock, retrying with a timeout, and latches an error after repeated failures. It then releases the Ethernet PHY reset, SoC reset, Ethernet MAC reset and PTP reset in a fixed order, so that no domain leaves reset before its clock is stable.

## Interface
Parameters:
- `MMCM_RST_CYCLES`, 16: cycles `mmcm_rst_o` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before an attempt fails.
- `MAX_RETRIES`, 4: failed lock attempts before ERR (≥1).
- `PHY_RST_CYCLES`, 2048: cycles `phy_reset_no` is held low after lock.
- `STAGE_GAP`, 8: cycles between consecutive domain releases (≥1).
- `DEBOUNCE_CYCLES`, 1024: cycles the synchronized button must be stably high to count as a press.

Ports:
- `clk_i`, in, 1: free-running reference clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `btn_rst_i`, in, 1: board reset button, active-high, asynchronous to `clk_i`.
- `mmcm_locked_i`, in, 1: MMCM LOCKED, asynchronous.
- `mmcm_rst_o`, out, 1: MMCM RST, active-high.
- `soc_rst_no`, out, 1: SoC reset, active-low.
- `eth_rst_o`, out, 1: Ethernet MAC reset, active-high.
- `ptp_rst_o`, out, 1: PTP reset, active-high.
- `phy_reset_no`, out, 1: external PHY reset, active-low.
- `seq_done_o`, out, 1: all domains released.
- `lock_err_o`, out, 1: lock retries exhausted.
- `retry_cnt_o`, out, 4: failed attempts in the current sequence.

## Operation
Input conditioning:
- `mmcm_locked_i` passes a 2-FF synchronizer; the result is `lock_s`.
- `btn_rst_i` passes a 2-FF synchronizer and debounce; the result is `btn_s`.

States: MMCM_RST, WAIT_LOCK, PHY_HOLD, REL_SOC, REL_ETH, REL_PTP, RUN, ERR. One shared cycle counter is cleared on every state entry.
- **MMCM_RST:** `mmcm_rst_o`=1, all domain resets asserted.
  - After `MMCM_RST_CYCLES` cycles → WAIT_LOCK.
  - While `btn_s`=1 the counter is held at 0.
- **WAIT_LOCK:** `mmcm_rst_o`=0.
  - `lock_s`=1 → PHY_HOLD.
  - Counter reaches `LOCK_TIMEOUT`-1 and `retry_cnt`<`MAX_RETRIES`-1 → increment `retry_cnt`, go to MMCM_RST.
  - Counter reaches `LOCK_TIMEOUT`-1 otherwise → increment `retry_cnt`, go to ERR.
- **PHY_HOLD:** after `PHY_RST_CYCLES` cycles, set `phy_reset_no`=1 → REL_SOC.
- **REL_SOC:** after `STAGE_GAP` cycles, set `soc_rst_no`=1 → REL_ETH.
- **REL_ETH:** after `STAGE_GAP` cycles, set `eth_rst_o`=0 → REL_PTP.
- **REL_PTP:** after `STAGE_GAP` cycles, set `ptp_rst_o`=0 and `seq_done_o`=1 → RUN.
- **RUN:** hold until an abort.
- **ERR:** `lock_err_o`=1, `mmcm_rst_o`=1, all domain resets asserted. Leave only on a button press.

Aborts (priority: button over lock loss):
- **Button:** a debounced press in any state → all resets asserted, `seq_done_o`=0, `lock_err_o`=0, `retry_cnt`=0 → MMCM_RST.
- **Lock loss:** `lock_s`=0 in PHY_HOLD through RUN → same as a button abort except `lock_err_o` is untouched.
- "All resets asserted" means `mmcm_rst_o`=1, `soc_rst_no`=0, `eth_rst_o`=1, `ptp_rst_o`=1, `phy_reset_no`=0.

Release order is fixed and never reordered: PHY, SoC, Ethernet MAC, PTP. Assertion on abort is simultaneous.

## Timing
- Reset values (`rst_ni`=0): `mmcm_rst_o`=1, `soc_rst_no`=0, `eth_rst_o`=1, `ptp_rst_o`=1, `phy_reset_no`=0, `seq_done_o`=0, `lock_err_o`=0, `retry_cnt_o`=0; state is MMCM_RST.
- All outputs are registered; no combinational input-to-output path.
- Lock latency: `mmcm_locked_i` rising → PHY_HOLD entry in 3 cycles (2 synchronizer + 1 FSM).
- Lock loss: `mmcm_locked_i` falling → resets asserted after 3 cycles.
- Release: PHY_HOLD entry → `seq_done_o`=1 after exactly `PHY_RST_CYCLES`+3·`STAGE_GAP` cycles.
- Debounce: a press is recognized `DEBOUNCE_CYCLES`+2 cycles after `btn_rst_i` rises and stays high. Any low sample restarts the debounce count.
- Counter width: `$clog2` of the largest cycle parameter. Comparisons are against parameter-1 and the counter never wraps.
- `retry_cnt` saturates at 15.
- Simultaneous lock-loss and button abort: the button abort wins and clears `lock_err_o`.

## Structure
- Package `fpga_rst_seq_pkg`: state enum `rst_seq_state_e`, counter-width function, and the default parameter values.
- Sub-module `fpga_rst_debounce`: 2-FF sync plus stable-high counter, parameter `DEBOUNCE_CYCLES`. It is instantiated for the button. `lock_s` uses a plain 2-FF synchronizer.

## Test plan
Bench parameters: `MMCM_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `MAX_RETRIES`=3, `PHY_RST_CYCLES`=10, `STAGE_GAP`=2, `DEBOUNCE_CYCLES`=4.
1. Lock 5 cycles after `mmcm_rst_o` falls → `phy_reset_no` rises 13 cycles after lock, then `soc_rst_no`, `eth_rst_o` and `ptp_rst_o` change at +2-cycle steps; `seq_done_o`=1 at lock+19 cycles.
2. Lock never asserts → three attempts of 4 reset cycles plus 20 wait cycles each, then `lock_err_o`=1, `retry_cnt_o`=3, `mmcm_rst_o`=1 held.
3. `mmcm_locked_i` drops during RUN → after 3 cycles all resets asserted and `seq_done_o`=0; relock replays the scenario 1 timing.
4. Button glitch of 3 cycles → no effect. A 6-cycle press in ERR → `lock_err_o`=0, `retry_cnt_o`=0, a new sequence starts after release.
5. `rst_ni` pulled low mid-REL_ETH → all outputs return to their reset values immediately (asynchronously).
6. Button press on the same cycle as a lock loss → `lock_err_o` cleared, `retry_cnt_o`=0.

Source files
------------

// File: rtl/fpga_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_rst_seq_pkg
// Purpose  : Shared types and defaults for the board clock/reset sequencer.
//            Provides the sequencer state enum, the default parameter values
//            and a helper that sizes the shared cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
package fpga_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_MMCM_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_PHY_HOLD  = 3'd2,
        ST_REL_SOC   = 3'd3,
        ST_REL_ETH   = 3'd4,
        ST_REL_PTP   = 3'd5,
        ST_RUN       = 3'd6,
        ST_ERR       = 3'd7
    } rst_seq_state_e;

    localparam int unsigned c_DEF_MMCM_RST_CYCLES = 16;
    localparam int unsigned c_DEF_LOCK_TIMEOUT    = 65536;
    localparam int unsigned c_DEF_MAX_RETRIES     = 4;
    localparam int unsigned c_DEF_PHY_RST_CYCLES  = 2048;
    localparam int unsigned c_DEF_STAGE_GAP       = 8;
    localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 1024;

    // Bits needed to count 0 .. max_val-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_rst_debounce.sv
`default_nettype none
// ============================================================================
// Module   : fpga_rst_debounce
// Purpose  : Two-flop synchronizer followed by a stable-high counter. The
//            output rises once the synchronized input has been sampled high
//            on DEBOUNCE_CYCLES consecutive cycles and drops on the first
//            low sample.
// Ports    : clk_i   - sampling clock
//            rst_ni  - asynchronous active-low reset
//            i_btn   - raw asynchronous button input, active-high
//            o_btn_s - debounced level, active-high
// Revision : 1.0 - initial release
// ============================================================================
module fpga_rst_debounce
    import fpga_rst_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_btn,
    output logic o_btn_s
);

    localparam int unsigned           c_CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_btn_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_cnt   <= '0;
            r_btn_s <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            if (!r_sync) begin
                // Any low sample restarts the qualification window.
                r_cnt   <= '0;
                r_btn_s <= 1'b0;
            end else if (r_cnt == c_LAST) begin
                // Counter parks here so it never wraps while held.
                r_btn_s <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_s = r_btn_s;

endmodule
`default_nettype wire

// File: rtl/fpga_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpga_rst_seq
// Purpose  : Board-level clock/reset sequencer on the free-running reference
//            clock. Pulses MMCM reset, waits for lock with timeout/retry,
//            latches an error after repeated failures, then releases PHY,
//            SoC, Ethernet MAC and PTP resets in that fixed order.
// Ports    : clk_i         - free-running reference clock
//            rst_ni        - asynchronous active-low reset
//            btn_rst_i     - board reset button, active-high, asynchronous
//            mmcm_locked_i - MMCM LOCKED, asynchronous
//            mmcm_rst_o    - MMCM RST, active-high
//            soc_rst_no    - SoC reset, active-low
//            eth_rst_o     - Ethernet MAC reset, active-high
//            ptp_rst_o     - PTP reset, active-high
//            phy_reset_no  - external PHY reset, active-low
//            seq_done_o    - all domains released
//            lock_err_o    - lock retries exhausted
//            retry_cnt_o   - failed lock attempts in the current sequence
// Revision : 1.0 - initial release
// ============================================================================
module fpga_rst_seq
    import fpga_rst_seq_pkg::*;
#(
    parameter int unsigned MMCM_RST_CYCLES = c_DEF_MMCM_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT    = c_DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRIES     = c_DEF_MAX_RETRIES,
    parameter int unsigned PHY_RST_CYCLES  = c_DEF_PHY_RST_CYCLES,
    parameter int unsigned STAGE_GAP       = c_DEF_STAGE_GAP,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_rst_i,
    input  logic       mmcm_locked_i,
    output logic       mmcm_rst_o,
    output logic       soc_rst_no,
    output logic       eth_rst_o,
    output logic       ptp_rst_o,
    output logic       phy_reset_no,
    output logic       seq_done_o,
    output logic       lock_err_o,
    output logic [3:0] retry_cnt_o
);

    localparam int unsigned c_MAX_AB  = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ?
                                        MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned c_MAX_CD  = (PHY_RST_CYCLES > STAGE_GAP) ?
                                        PHY_RST_CYCLES : STAGE_GAP;
    localparam int unsigned c_MAX_CYC = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int unsigned c_CNT_W   = cnt_width(c_MAX_CYC);

    localparam logic [c_CNT_W-1:0] c_MMCM_LAST = c_CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_PHY_LAST  = c_CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_lock_meta;
    logic r_lock_s;
    logic w_btn_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    fpga_rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_btn   (btn_rst_i),
        .o_btn_s (w_btn_s)
    );

    // ------------------------------------------------------------------
    // Sequencer: state, shared counter and output registers
    // ------------------------------------------------------------------
    rst_seq_state_e     r_state,  w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [3:0]         r_retry,  w_retry_nxt;
    logic               r_mmcm_rst,  w_mmcm_rst_nxt;
    logic               r_soc_rst_n, w_soc_rst_n_nxt;
    logic               r_eth_rst,   w_eth_rst_nxt;
    logic               r_ptp_rst,   w_ptp_rst_nxt;
    logic               r_phy_rst_n, w_phy_rst_n_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_err,       w_err_nxt;
    logic [3:0]         w_retry_inc;
    logic               w_retry_left;

    assign w_retry_inc  = (r_retry == 4'd15) ? 4'd15 : (r_retry + 4'd1);
    assign w_retry_left = (32'(r_retry) < (MAX_RETRIES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_MMCM_RST;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_mmcm_rst  <= 1'b1;
            r_soc_rst_n <= 1'b0;
            r_eth_rst   <= 1'b1;
            r_ptp_rst   <= 1'b1;
            r_phy_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_mmcm_rst  <= w_mmcm_rst_nxt;
            r_soc_rst_n <= w_soc_rst_n_nxt;
            r_eth_rst   <= w_eth_rst_nxt;
            r_ptp_rst   <= w_ptp_rst_nxt;
            r_phy_rst_n <= w_phy_rst_n_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_mmcm_rst_nxt  = r_mmcm_rst;
        w_soc_rst_n_nxt = r_soc_rst_n;
        w_eth_rst_nxt   = r_eth_rst;
        w_ptp_rst_nxt   = r_ptp_rst;
        w_phy_rst_n_nxt = r_phy_rst_n;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;

        case (r_state)
            ST_MMCM_RST: begin
                if (r_cnt == c_MMCM_LAST) begin
                    w_state_nxt    = ST_WAIT_LOCK;
                    w_cnt_nxt      = '0;
                    w_mmcm_rst_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_PHY_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LOCK_LAST) begin
                    w_cnt_nxt      = '0;
                    w_retry_nxt    = w_retry_inc;
                    w_mmcm_rst_nxt = 1'b1;
                    if (w_retry_left) begin
                        w_state_nxt = ST_MMCM_RST;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PHY_HOLD: begin
                if (r_cnt == c_PHY_LAST) begin
                    w_state_nxt     = ST_REL_SOC;
                    w_cnt_nxt       = '0;
                    w_phy_rst_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_REL_SOC: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt     = ST_REL_ETH;
                    w_cnt_nxt       = '0;
                    w_soc_rst_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_REL_ETH: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt   = ST_REL_PTP;
                    w_cnt_nxt     = '0;
                    w_eth_rst_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_REL_PTP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                    w_ptp_rst_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN, ST_ERR: begin
                // Parked states: counter held so it cannot wrap.
            end
            default: begin
                w_state_nxt = ST_MMCM_RST;
                w_cnt_nxt   = '0;
            end
        endcase

        // Lock loss once the clock has been declared good restarts the
        // whole sequence; the error flag is left alone.
        if (!r_lock_s && (r_state inside {ST_PHY_HOLD, ST_REL_SOC, ST_REL_ETH,
                                          ST_REL_PTP, ST_RUN})) begin
            w_state_nxt     = ST_MMCM_RST;
            w_cnt_nxt       = '0;
            w_retry_nxt     = 4'd0;
            w_mmcm_rst_nxt  = 1'b1;
            w_soc_rst_n_nxt = 1'b0;
            w_eth_rst_nxt   = 1'b1;
            w_ptp_rst_nxt   = 1'b1;
            w_phy_rst_n_nxt = 1'b0;
            w_done_nxt      = 1'b0;
        end

        // Button is evaluated last so it overrides a coincident lock loss.
        // Holding the button keeps re-entering MMCM_RST, which holds the
        // counter at zero.
        if (w_btn_s) begin
            w_state_nxt     = ST_MMCM_RST;
            w_cnt_nxt       = '0;
            w_retry_nxt     = 4'd0;
            w_mmcm_rst_nxt  = 1'b1;
            w_soc_rst_n_nxt = 1'b0;
            w_eth_rst_nxt   = 1'b1;
            w_ptp_rst_nxt   = 1'b1;
            w_phy_rst_n_nxt = 1'b0;
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
        end
    end

    assign mmcm_rst_o   = r_mmcm_rst;
    assign soc_rst_no   = r_soc_rst_n;
    assign eth_rst_o    = r_eth_rst;
    assign ptp_rst_o    = r_ptp_rst;
    assign phy_reset_no = r_phy_rst_n;
    assign seq_done_o   = r_done;
    assign lock_err_o   = r_err;
    assign retry_cnt_o  = r_retry;

endmodule
`default_nettype wire
